// File: rtl/serpent_fetch_realign.sv
// serpent_fetch_realign
// Buffers 32-bit icache fetch words in a small FIFO and realigns them into
// single RISC-V instructions for decode. The icache response cannot be
// stalled, so new requests are throttled by an in-flight credit counter.
// Build option: SERPENT_FETCH_RVC_EN enables 16-bit (RVC) realignment; when
// undefined, every fetch word is handed out as one 32-bit instruction.

// Protocol watchdog for the icache/frontend side of the block.
module serpent_fetch_realign_chk #(
  parameter int CW = 3
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic          flush_i,
  input logic          issue_i,
  input logic          issue_en_i,
  input logic          kill_s2_i,
  input logic          fetch_valid_i,
  input logic          fifo_full_i,
  input logic [CW-1:0] inflight_i
);

  // Flag a write into a full FIFO, a credit underflow, or an issue without credit.
  always @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      a_no_write_full: assert (!(fetch_valid_i && fifo_full_i));
      a_no_underflow: assert (!((fetch_valid_i || kill_s2_i) && !issue_i && (inflight_i == {CW{1'b0}})));
      a_issue_credit: assert (!(issue_i && !issue_en_i));
    end
  end

endmodule

module serpent_fetch_realign #(
  parameter int DEPTH       = 4,
  parameter int VADDR_WIDTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   issue_i,
  input  logic                   kill_s2_i,
  input  logic                   fetch_valid_i,
  input  logic [31:0]            fetch_data_i,
  input  logic [VADDR_WIDTH-1:0] fetch_vaddr_i,
  input  logic                   fetch_ex_i,
  output logic                   issue_en_o,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [31:0]            instr_o,
  output logic [VADDR_WIDTH-1:0] instr_vaddr_o,
  output logic                   instr_is_rvc_o,
  output logic                   instr_ex_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [AW-1:0] P_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  // FIFO storage and bookkeeping
  logic [31:0]            r_mem_data  [DEPTH];
  logic [VADDR_WIDTH-1:0] r_mem_vaddr [DEPTH];
  logic                   r_mem_ex    [DEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          r_inflight;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_inc;
  logic                   w_dec;
  logic [CW:0]            w_credit_sum;
  logic [31:0]            w_head_data;
  logic [VADDR_WIDTH-1:0] w_head_vaddr;
  logic                   w_head_ex;

  // Candidate instruction presented to decode
  logic                   w_valid;
  logic [31:0]            w_instr;
  logic [VADDR_WIDTH-1:0] w_vaddr;
  logic                   w_rvc;
  logic                   w_ex;

  assign w_full       = (r_count == C_DEPTH);
  assign w_empty      = (r_count == C_ZERO);
  assign w_push       = fetch_valid_i & ~flush_i & ~w_full;
  assign w_inc        = issue_i;
  assign w_dec        = fetch_valid_i | kill_s2_i;
  assign w_head_data  = r_mem_data[r_rptr];
  assign w_head_vaddr = r_mem_vaddr[r_rptr];
  assign w_head_ex    = r_mem_ex[r_rptr];

  // A request may issue only if its response is guaranteed a FIFO slot.
  assign w_credit_sum = {1'b0, r_count} + {1'b0, r_inflight};
  assign issue_en_o   = (w_credit_sum < {1'b0, C_DEPTH});

  // Track requests accepted by the icache whose response has not yet arrived.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_inflight <= C_ZERO;
    end else if (flush_i) begin
      r_inflight <= C_ZERO;
    end else if (w_inc && !w_dec) begin
      r_inflight <= r_inflight + C_ONE;
    end else if (!w_inc && w_dec && (r_inflight != C_ZERO)) begin
      r_inflight <= r_inflight - C_ONE;
    end else begin
      r_inflight <= r_inflight;
    end
  end

  // FIFO pointers and occupancy; a flush empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr  <= P_ZERO;
      r_rptr  <= P_ZERO;
      r_count <= C_ZERO;
    end else if (flush_i) begin
      r_wptr  <= P_ZERO;
      r_rptr  <= P_ZERO;
      r_count <= C_ZERO;
    end else begin
      r_wptr <= w_push ? (r_wptr + P_ONE) : r_wptr;
      r_rptr <= w_pop ? (r_rptr + P_ONE) : r_rptr;
      if (w_push && !w_pop) begin
        r_count <= r_count + C_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - C_ONE;
      end else begin
        r_count <= r_count;
      end
    end
  end

  // FIFO payload write; storage needs no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wptr]  <= fetch_data_i;
      r_mem_vaddr[r_wptr] <= fetch_vaddr_i;
      r_mem_ex[r_wptr]    <= fetch_ex_i;
    end
  end

`ifdef SERPENT_FETCH_RVC_EN

  typedef enum logic [2:0] {
    ACT_NONE    = 3'd0,
    ACT_EX      = 3'd1,
    ACT_STRAD   = 3'd2,
    ACT_RVC     = 3'd3,
    ACT_FULL    = 3'd4,
    ACT_CAPTURE = 3'd5
  } act_e;

  // Realign state: r_off_set=0 means the head is fresh and its offset comes from vaddr[1].
  logic                   r_off_set;
  logic                   r_offset;
  logic                   r_strad_valid;
  logic [15:0]            r_strad_lo;
  logic [VADDR_WIDTH-1:0] r_strad_vaddr;

  logic                   w_off;
  logic [15:0]            w_half;
  logic                   w_half_rvc;
  logic                   w_fire;
  act_e                   w_act;

  assign w_off      = r_off_set ? r_offset : w_head_vaddr[1];
  assign w_half     = w_off ? w_head_data[31:16] : w_head_data[15:0];
  assign w_half_rvc = (w_half[1:0] != 2'b11);
  assign w_fire     = w_valid & instr_ready_i;

  // Classify the head word and build the instruction it yields this cycle.
  always_comb begin
    w_act   = ACT_NONE;
    w_valid = 1'b0;
    w_instr = 32'h0000_0000;
    w_vaddr = {VADDR_WIDTH{1'b0}};
    w_rvc   = 1'b0;
    w_ex    = 1'b0;
    if (w_empty) begin
      w_act = ACT_NONE;
    end else if (w_head_ex) begin
      // A faulting word closes any pending straddle with the fault attached.
      w_act   = ACT_EX;
      w_valid = 1'b1;
      w_ex    = 1'b1;
      if (r_strad_valid) begin
        w_instr = {w_head_data[15:0], r_strad_lo};
        w_vaddr = r_strad_vaddr;
      end else begin
        w_instr = w_head_data;
        w_vaddr = w_head_vaddr;
      end
    end else if (r_strad_valid) begin
      w_act   = ACT_STRAD;
      w_valid = 1'b1;
      w_instr = {w_head_data[15:0], r_strad_lo};
      w_vaddr = r_strad_vaddr;
    end else if (w_half_rvc) begin
      w_act   = ACT_RVC;
      w_valid = 1'b1;
      w_rvc   = 1'b1;
      w_instr = {16'h0000, w_half};
      w_vaddr = {w_head_vaddr[VADDR_WIDTH-1:2], w_off, 1'b0};
    end else if (!w_off) begin
      w_act   = ACT_FULL;
      w_valid = 1'b1;
      w_instr = w_head_data;
      w_vaddr = {w_head_vaddr[VADDR_WIDTH-1:2], 2'b00};
    end else begin
      // Upper half starts a 32-bit instruction; its tail lives in the next word.
      w_act = ACT_CAPTURE;
    end
  end

  // Retire the head word once everything in it has been consumed.
  always_comb begin
    w_pop = 1'b0;
    case (w_act)
      ACT_EX, ACT_FULL: w_pop = w_fire;
      ACT_RVC:          w_pop = w_fire & w_off;
      ACT_CAPTURE:      w_pop = 1'b1;
      default:          w_pop = 1'b0;
    endcase
  end

  // Advance the half-word offset and straddle buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_off_set     <= 1'b0;
      r_offset      <= 1'b0;
      r_strad_valid <= 1'b0;
      r_strad_lo    <= 16'h0000;
      r_strad_vaddr <= {VADDR_WIDTH{1'b0}};
    end else begin
      case (w_act)
        ACT_EX: begin
          if (w_fire) begin
            r_strad_valid <= 1'b0;
            r_off_set     <= 1'b0;
            r_offset      <= 1'b0;
          end
        end
        ACT_STRAD: begin
          if (w_fire) begin
            r_strad_valid <= 1'b0;
            r_off_set     <= 1'b1;
            r_offset      <= 1'b1;
          end
        end
        ACT_RVC: begin
          if (w_fire) begin
            r_off_set <= ~w_off;
            r_offset  <= ~w_off;
          end
        end
        ACT_FULL: begin
          if (w_fire) begin
            r_off_set <= 1'b0;
            r_offset  <= 1'b0;
          end
        end
        ACT_CAPTURE: begin
          r_strad_valid <= 1'b1;
          r_strad_lo    <= w_head_data[31:16];
          r_strad_vaddr <= {w_head_vaddr[VADDR_WIDTH-1:2], 2'b10};
          r_off_set     <= 1'b0;
          r_offset      <= 1'b0;
        end
        default: begin
          r_off_set <= r_off_set;
        end
      endcase
    end
  end

`else

  logic w_unused_vaddr_lo;
  assign w_unused_vaddr_lo = ^w_head_vaddr[1:0];

  // One instruction per fetch word, reported at the word-aligned address.
  always_comb begin
    w_valid = 1'b0;
    w_instr = 32'h0000_0000;
    w_vaddr = {VADDR_WIDTH{1'b0}};
    w_rvc   = 1'b0;
    w_ex    = 1'b0;
    w_pop   = 1'b0;
    if (!w_empty) begin
      w_valid = 1'b1;
      w_instr = w_head_data;
      w_vaddr = {w_head_vaddr[VADDR_WIDTH-1:2], 2'b00};
      w_ex    = w_head_ex;
      w_pop   = instr_ready_i;
    end else begin
      w_pop = 1'b0;
    end
  end

`endif

  assign instr_valid_o  = w_valid;
  assign instr_o        = w_instr;
  assign instr_vaddr_o  = w_vaddr;
  assign instr_is_rvc_o = w_rvc;
  assign instr_ex_o     = w_ex;

  serpent_fetch_realign_chk #(
    .CW (CW)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .issue_i       (issue_i),
    .issue_en_i    (issue_en_o),
    .kill_s2_i     (kill_s2_i),
    .fetch_valid_i (fetch_valid_i),
    .fifo_full_i   (w_full),
    .inflight_i    (r_inflight)
  );

endmodule

// File: tb/tb_serpent_fetch_realign.sv
// Self-checking bench for serpent_fetch_realign: directed scenarios plus
// randomized word streams compared against a halfword-parsing reference model.
module tb_serpent_fetch_realign;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        issue_i = 1'b0;
  logic        kill_s2_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] fetch_data_i = 32'h0;
  logic [63:0] fetch_vaddr_i = 64'h0;
  logic        fetch_ex_i = 1'b0;
  logic        issue_en_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [63:0] instr_vaddr_o;
  logic        instr_is_rvc_o;
  logic        instr_ex_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] vaddr;
    logic        rvc;
    logic        ex;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] w_data  [64];
  logic [63:0] w_vaddr [64];
  logic        w_ex    [64];

  serpent_fetch_realign #(.DEPTH(4), .VADDR_WIDTH(64)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .issue_i        (issue_i),
    .kill_s2_i      (kill_s2_i),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_data_i   (fetch_data_i),
    .fetch_vaddr_i  (fetch_vaddr_i),
    .fetch_ex_i     (fetch_ex_i),
    .issue_en_o     (issue_en_o),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_o        (instr_o),
    .instr_vaddr_o  (instr_vaddr_o),
    .instr_is_rvc_o (instr_is_rvc_o),
    .instr_ex_o     (instr_ex_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int k, input logic [31:0] d, input logic [63:0] v, input logic e);
    w_data[k]  = d;
    w_vaddr[k] = v;
    w_ex[k]    = e;
  endtask

  // Reference model: walk the halfword stream of the given words.
  task automatic build_expected(input int nw);
    logic        pend;
    logic [15:0] lo;
    logic [63:0] paddr;
    logic [63:0] base;
    logic [15:0] h;
    int          pos;
    exp_q.delete();
    pend = 1'b0;
    lo = 16'h0;
    paddr = 64'h0;
    for (int k = 0; k < nw; k++) begin
      base = {w_vaddr[k][63:2], 2'b00};
`ifdef SERPENT_FETCH_RVC_EN
      if (w_ex[k]) begin
        if (pend) exp_q.push_back('{{w_data[k][15:0], lo}, paddr, 1'b0, 1'b1});
        else      exp_q.push_back('{w_data[k], w_vaddr[k], 1'b0, 1'b1});
        pend = 1'b0;
      end else begin
        if (pend) begin
          exp_q.push_back('{{w_data[k][15:0], lo}, paddr, 1'b0, 1'b0});
          pend = 1'b0;
          pos = 1;
        end else begin
          pos = int'(w_vaddr[k][1]);
        end
        while (pos < 2) begin
          h = (pos == 0) ? w_data[k][15:0] : w_data[k][31:16];
          if (h[1:0] != 2'b11) begin
            exp_q.push_back('{{16'h0000, h}, base + 64'(2 * pos), 1'b1, 1'b0});
            pos++;
          end else if (pos == 0) begin
            exp_q.push_back('{w_data[k], base, 1'b0, 1'b0});
            pos = 2;
          end else begin
            pend = 1'b1;
            lo = h;
            paddr = base + 64'd2;
            pos = 2;
          end
        end
      end
`else
      exp_q.push_back('{w_data[k], base, 1'b0, w_ex[k]});
`endif
    end
  endtask

  // Feed nw words (issue and return in the same cycle) and score every handshake.
  task automatic run_stream(input int nw, input bit rand_ready);
    int widx;
    int guard;
    exp_t e;
    build_expected(nw);
    widx = 0;
    guard = 0;
    while ((widx < nw || exp_q.size() != 0) && guard < 3000) begin
      @(posedge clk_i); #1;
      issue_i = 1'b0;
      fetch_valid_i = 1'b0;
      if (widx < nw && issue_en_o && (!rand_ready || $urandom_range(0, 3) != 0)) begin
        fetch_data_i  = w_data[widx];
        fetch_vaddr_i = w_vaddr[widx];
        fetch_ex_i    = w_ex[widx];
        issue_i       = 1'b1;
        fetch_valid_i = 1'b1;
        widx++;
      end
      instr_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk_i);
      if (instr_valid_o && instr_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("extra_instr", instr_o, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("instr", instr_o, e.instr);
          chk("vaddr", instr_vaddr_o, e.vaddr);
          chk("rvc", instr_is_rvc_o, e.rvc);
          chk("ex", instr_ex_o, e.ex);
        end
      end
      guard++;
    end
    chk("stream_pending", exp_q.size(), 0);
    @(posedge clk_i); #1;
    issue_i = 1'b0;
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b0;
  endtask

  task automatic do_flush();
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
  endtask

  task automatic issue_n_check(input string tag);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk_i); #1;
      issue_i = 1'b1;
      @(posedge clk_i); #1;
      issue_i = 1'b0;
      @(negedge clk_i);
      chk(tag, issue_en_o, (i < 4) ? 64'd1 : 64'd0);
    end
  endtask

  initial begin
    logic [63:0] base;
    // Reset
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_issue_en", issue_en_o, 1);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_vaddr", instr_vaddr_o, 0);
    chk("rst_rvc", instr_is_rvc_o, 0);
    chk("rst_ex", instr_ex_o, 0);

    // Credits: four outstanding requests exhaust DEPTH=4
    issue_n_check("credit_issue_en");
    @(posedge clk_i); #1 kill_s2_i = 1'b1;
    @(posedge clk_i); #1 kill_s2_i = 1'b0;
    @(negedge clk_i);
    chk("credit_after_kill", issue_en_o, 1);
    do_flush();

    // Single 32-bit word: valid exactly one cycle after the write
    @(posedge clk_i); #1;
    fetch_data_i = 32'h0013_8513; fetch_vaddr_i = 64'h1000; fetch_ex_i = 1'b0;
    issue_i = 1'b1; fetch_valid_i = 1'b1; instr_ready_i = 1'b1;
    @(negedge clk_i);
    chk("no_bypass", instr_valid_o, 0);
    @(posedge clk_i); #1;
    issue_i = 1'b0; fetch_valid_i = 1'b0;
    @(negedge clk_i);
    chk("w0_valid", instr_valid_o, 1);
    chk("w0_instr", instr_o, 64'h0013_8513);
    chk("w0_vaddr", instr_vaddr_o, 64'h1000);
    chk("w0_rvc", instr_is_rvc_o, 0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("w0_consumed", instr_valid_o, 0);

    // Two RVC in one word
    set_word(0, 32'h4581_4501, 64'h2000, 1'b0);
    run_stream(1, 1'b0);
    // RVC, straddling 32-bit, RVC
    set_word(0, 32'h0513_4501, 64'h3000, 1'b0);
    set_word(1, 32'h4581_0013, 64'h3004, 1'b0);
    run_stream(2, 1'b0);
    // Same with a fault on the second word
    set_word(1, 32'h4581_0013, 64'h3004, 1'b1);
    run_stream(2, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("ex_empty_valid", instr_valid_o, 0);
    chk("ex_empty_issue_en", issue_en_o, 1);
    do_flush();

    // Stall with 4 words buffered, then flush
    set_word(0, 32'h0013_8513, 64'h4000, 1'b0);
    set_word(1, 32'h00a0_0093, 64'h4004, 1'b0);
    set_word(2, 32'h40b5_0533, 64'h4008, 1'b0);
    set_word(3, 32'h00c5_8593, 64'h400c, 1'b0);
    build_expected(4);
    instr_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i); #1;
      fetch_data_i = w_data[k]; fetch_vaddr_i = w_vaddr[k]; fetch_ex_i = w_ex[k];
      issue_i = 1'b1; fetch_valid_i = 1'b1;
    end
    @(posedge clk_i); #1;
    issue_i = 1'b0; fetch_valid_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      chk("stall_valid", instr_valid_o, 1);
      chk("stall_instr", instr_o, exp_q[0].instr);
      chk("stall_vaddr", instr_vaddr_o, exp_q[0].vaddr);
      chk("stall_issue_en", issue_en_o, 0);
      @(posedge clk_i); #1;
    end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_valid", instr_valid_o, 0);
    chk("flush_issue_en", issue_en_o, 1);
    issue_n_check("flush_credit");
    do_flush();

    // Randomized streams
    for (int b = 0; b < 3; b++) begin
      base = 64'h8000_0000 + 64'(($urandom_range(0, 1023)) * 4);
      for (int k = 0; k < 48; k++) begin
        set_word(k, $urandom, base + 64'(4 * k), ($urandom_range(0, 15) == 0));
      end
      w_vaddr[0] = base | ($urandom_range(0, 1) != 0 ? 64'd2 : 64'd0);
      run_stream(48, 1'b1);
      do_flush();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
